// File: rtl/byte_stream_ram_if.sv
// Control and status signals of the byte-stream packet buffer.
// The bidirectional data bus stays a plain inout port on the RAM itself.
interface byte_stream_ram_if #(
  parameter int DEPTH = 128
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              oe_i;
  logic              stb_i;
  logic              cmd_i;
  logic              rd_i;
  logic              dvalid_o;
  logic              busy_o;
  logic              mode_o;
  logic [ADDR_W-1:0] addr_o;
  logic              wrap_o;
  logic              err_o;

  modport slave (
    input  oe_i, stb_i, cmd_i, rd_i,
    output dvalid_o, busy_o, mode_o, addr_o, wrap_o, err_o
  );

  modport master (
    output oe_i, stb_i, cmd_i, rd_i,
    input  dvalid_o, busy_o, mode_o, addr_o, wrap_o, err_o
  );
endinterface

// File: rtl/byte_stream_ram.sv
// Single-port RAM on a shared byte bus with an auto-incrementing pointer.
// The cmd_i qualifier separates commands from data, so every data value can be stored.
module byte_stream_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  inout  wire  [DATA_W-1:0] data_io,
  byte_stream_ram_if.slave  bus
);
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W:0]   DEPTH_EXT = (DATA_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_LD,
    CLEAR
  } state_t;

  state_t            state;
  logic              mode;
  logic              dvalid;
  logic              busy;
  logic              wrap;
  logic              err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              host_stb;
  logic              host_rd;
  logic              cmd_legal;
  logic              addr_wraps;
  logic [ADDR_W-1:0] addr_inc;
  logic              we;
  logic [DATA_W-1:0] wdata;

  assign host_stb   = bus.stb_i & ~bus.oe_i;
  assign host_rd    = bus.rd_i & bus.oe_i;
  assign cmd_legal  = ((data_io >> 2) == '0);
  assign addr_wraps = (addr == LAST_ADDR);
  assign addr_inc   = addr_wraps ? '0 : addr + ADDR_W'(1);

  // CLEAR reuses the pointer as its sweep counter, so a single write port suffices.
  always_comb begin
    we    = 1'b0;
    wdata = data_io;
    if (!rst_i) begin
      case (state)
        CLEAR: begin
          we    = 1'b1;
          wdata = '0;
        end
        IDLE:    we = mode & host_stb & ~bus.cmd_i;
        default: we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mode    <= 1'b0;
      addr    <= '0;
      rdata_q <= '0;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (host_stb && bus.cmd_i) begin
            if (!cmd_legal) begin
              err <= 1'b1;
            end else begin
              case (data_io[1:0])
                2'd0: mode <= 1'b0;
                2'd1: mode <= 1'b1;
                2'd2: state <= ADDR_LD;
                default: begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  addr  <= '0;
                end
              endcase
            end
          end else if (host_stb) begin
            if (mode) begin
              addr <= addr_inc;
              wrap <= addr_wraps;
            end else begin
              err <= 1'b1;
            end
          end else if (host_rd) begin
            if (!mode) begin
              rdata_q <= mem[addr];
              dvalid  <= 1'b1;
              addr    <= addr_inc;
              wrap    <= addr_wraps;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ADDR_LD: begin
          if (host_stb) begin
            state <= IDLE;
            if (bus.cmd_i || ({1'b0, data_io} >= DEPTH_EXT)) begin
              err <= 1'b1;
            end else begin
              addr <= data_io[ADDR_W-1:0];
            end
          end
        end
        CLEAR: begin
          if (host_stb || host_rd) begin
            err <= 1'b1;
          end
          addr <= addr_inc;
          if (addr_wraps) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_io      = bus.oe_i ? rdata_q : 'z;
  assign bus.dvalid_o = dvalid;
  assign bus.busy_o   = busy;
  assign bus.mode_o   = mode;
  assign bus.addr_o   = addr;
  assign bus.wrap_o   = wrap;
  assign bus.err_o    = err;
endmodule
